pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Drives write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three events: load-use stalls, taken branch/jump flushes, and multi-cycle data-memory freezes.
- Holds a small FSM for memory waits, plus a wait-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, freeze cycles in MEM_WAIT before mem_err_o sets (range 2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- id_rs_i  in  5  rs of instruction in ID.
- id_rt_i  in  5  rt of instruction in ID.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rt_i  in  5  destination rt of instruction in EX.
- branch_taken_i  in  1  taken branch resolved in ID.
- jump_i  in  1  jump decoded in ID.
- mem_req_i  in  1  instruction in MEM accesses data memory.
- mem_ack_i  in  1  data memory completes the access this cycle.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  load NOP into IF/ID.
- idex_bubble_o  out  1  load zero control into ID/EX.
- exmem_we_o  out  1  EX/MEM write enable (ID/EX write enable is the same signal).
- memwb_bubble_o  out  1  load zero WB control into MEM/WB.
- mem_err_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  load-use stall cycles.
- freeze_cnt_o  out  CNT_W  memory-freeze cycles.

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous and active-high.
- Reset state and outputs:
  - FSM in RUN; wait counter 0; mem_err_o=0; both counters 0.
  - While rst_i=1: all write enables 0; ifid_flush_o, idex_bubble_o and memwb_bubble_o all 1.
- Control outputs are combinational from state and inputs; zero-cycle latency to the pipeline registers.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req_i=1 and mem_ack_i=0.
  - If mem_req_i=1 and mem_ack_i=1 in the same cycle, stay in RUN with no freeze.
  - MEM_WAIT -> RUN on mem_ack_i=1.
- Freeze cycle (mem_req_i=1 and mem_ack_i=0, in either state):
  - pc_we_o=0, ifid_we_o=0, exmem_we_o=0, memwb_bubble_o=1.
  - Hazard and branch inputs ignored: ifid_flush_o=0, idex_bubble_o=0.
- Ack cycle in MEM_WAIT: all enables 1; hazard logic evaluated normally.
- Load-use condition: ex_memread_i=1, ex_rt_i!=0, and ex_rt_i equals id_rs_i or id_rt_i.
  - Response: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1; exmem_we_o=1.
  - Lasts exactly one cycle per hazard instance.
- Flush: branch_taken_i or jump_i gives ifid_flush_o=1, with pc_we_o=1 and ifid_we_o=1.
- Priority: freeze > load-use > flush.
  - With load-use and flush both present, only the load-use stall is applied.
  - The branch re-resolves next cycle.
- Normal cycle: pc_we_o, ifid_we_o, exmem_we_o = 1; all bubble/flush outputs 0.
- Wait counter (8-bit):
  - Cleared on entering RUN.
  - Increments each cycle in MEM_WAIT.
  - Reaching MEM_TIMEOUT sets mem_err_o; the FSM stays in MEM_WAIT.
  - mem_err_o clears only on rst_i.
- Counters saturate at all-ones, never wrap.
  - stall_cnt_o increments on each load-use stall cycle.
  - freeze_cnt_o increments on each freeze cycle.
- Reset asserted mid-MEM_WAIT: the next cycle is RUN, counters zero, mem_err_o=0.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined: stall_cnt_o and freeze_cnt_o are implemented as specified.
- Undefined: both outputs are tied to 0, no counter flops exist, and ports remain present.

Test Plan:
- Reset: hold rst_i 2 cycles -> all *_we_o=0, flush/bubbles=1, mem_err_o=0; release -> pc_we_o=ifid_we_o=exmem_we_o=1, bubbles 0.
- Load-use: ex_memread_i=1, ex_rt_i=5, id_rs_i=5 for 1 cycle -> pc_we_o=0, ifid_we_o=0, idex_bubble_o=1 for 1 cycle, stall_cnt_o=1. Repeat with ex_rt_i=0 -> no stall.
- Memory freeze: mem_req_i=1, mem_ack_i asserted 4 cycles later -> 4 freeze cycles (pc/ifid/exmem we=0, memwb_bubble_o=1), freeze_cnt_o=4, RUN on ack cycle; mem_req_i with same-cycle ack -> no freeze.
- Priority: load-use and branch_taken_i together -> idex_bubble_o=1, ifid_flush_o=0. Load-use and branch during freeze -> neither asserted.
- Timeout: MEM_TIMEOUT=8, mem_req_i held with no ack for 10 cycles -> mem_err_o=1 from cycle 8 and sticky after ack; cleared only by rst_i.
- Saturation (CNT_W=4): 20 load-use stalls -> stall_cnt_o=15. With macro undefined -> both counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, data-memory freezes with a timeout watchdog.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_we_o,
  output logic             memwb_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_err_reg, mem_err_next;

  logic freeze, load_use, flush;

  assign freeze   = mem_req_i & ~mem_ack_i;
  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign flush    = branch_taken_i | jump_i;

  // Priority: reset > freeze > load-use > flush > normal.
  always_comb begin
    pc_we_o        = 1'b1;
    ifid_we_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_we_o     = 1'b1;
    memwb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_bubble_o  = 1'b1;
    end else if (flush) begin
      ifid_flush_o   = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    case (state_reg)
      RUN: begin
        if (freeze) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else begin
          // Saturate so a very long wait cannot wrap back below the threshold.
          if (wait_cnt_reg != 8'hFF) wait_cnt_next = wait_cnt_reg + 8'd1;
          if (wait_cnt_next == TIMEOUT_VAL) mem_err_next = 1'b1;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  assign mem_err_o = mem_err_reg;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg, freeze_cnt_reg;
  logic             stall_evt, freeze_evt;

  assign stall_evt  = ~freeze & load_use;
  assign freeze_evt = freeze;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (freeze_evt && (freeze_cnt_reg != '1))
        freeze_cnt_reg <= freeze_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt_o  = stall_cnt_reg;
  assign freeze_cnt_o = freeze_cnt_reg;
`else
  assign stall_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule
